// File: rtl/sram_sdp_be.sv
// Simple-dual-port SRAM with per-byte write enables, selectable read-during-write
// behaviour and a one-word-per-cycle clear engine started by reset.
module sram_sdp_be #(
    parameter int                 D_WIDTH   = 32,
    parameter int                 A_WIDTH   = 8,
    parameter int                 DEPTH     = 2**A_WIDTH,
    parameter int                 RDW_MODE  = 0,
    parameter logic [D_WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Wr_En,
    input  logic [A_WIDTH-1:0]     Wr_Addr,
    input  logic [D_WIDTH-1:0]     Wr_Data,
    input  logic [D_WIDTH/8-1:0]   Wr_Be,
    input  logic                   Rd_En,
    input  logic [A_WIDTH-1:0]     Rd_Addr,
    output logic [D_WIDTH-1:0]     Rd_Data,
    output logic                   Rd_Valid,
    output logic                   Rd_Err,
    output logic                   Busy
);

    localparam int                 NBYTES    = D_WIDTH / 8;
    localparam logic [A_WIDTH:0]   DEPTH_W   = (A_WIDTH+1)'(DEPTH);
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t               r_State;
    state_t               w_NextState;
    logic [A_WIDTH-1:0]   r_Ptr;
    logic [D_WIDTH-1:0]   r_Mem [0:DEPTH-1];
    logic [D_WIDTH-1:0]   r_RdData;
    logic                 r_RdValid;
    logic                 r_RdErr;

    logic                 w_Idle;
    logic                 w_Clearing;
    logic                 w_WrOk;
    logic                 w_RdInRange;
    logic [A_WIDTH-1:0]   w_RdIdx;
    logic [D_WIDTH-1:0]   w_RdWord;

    // Requests are only honoured once the clear engine has finished and reset is low.
    assign w_Idle      = (r_State == IDLE) && !Rst;
    assign w_Clearing  = (r_State == CLEAR) && !Rst;
    assign w_WrOk      = w_Idle && Wr_En && ({1'b0, Wr_Addr} < DEPTH_W);
    assign w_RdInRange = {1'b0, Rd_Addr} < DEPTH_W;
    assign w_RdIdx     = w_RdInRange ? Rd_Addr : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_State <= CLEAR;
            r_Ptr   <= '0;
        end else begin
            r_State <= w_NextState;
            if (r_State == CLEAR) begin
                r_Ptr <= r_Ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            CLEAR:   if (r_Ptr == LAST_ADDR) w_NextState = IDLE;
            IDLE:    w_NextState = IDLE;
            default: w_NextState = CLEAR;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_Clearing) begin
            r_Mem[r_Ptr] <= CLR_VALUE;
        end else if (w_WrOk) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (Wr_Be[i]) begin
                    r_Mem[Wr_Addr][8*i +: 8] <= Wr_Data[8*i +: 8];
                end
            end
        end
    end

    // New-data mode forwards the enabled write bytes over the stored word.
    always_comb begin
        w_RdWord = r_Mem[w_RdIdx];
        if (RDW_MODE == 1 && w_WrOk && (Wr_Addr == Rd_Addr)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (Wr_Be[i]) begin
                    w_RdWord[8*i +: 8] = Wr_Data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_RdValid <= 1'b0;
            r_RdErr   <= 1'b0;
            r_RdData  <= '0;
        end else if (w_Idle && Rd_En) begin
            r_RdValid <= 1'b1;
            r_RdErr   <= !w_RdInRange;
            r_RdData  <= w_RdInRange ? w_RdWord : '0;
        end else begin
            r_RdValid <= 1'b0;
            r_RdErr   <= 1'b0;
            r_RdData  <= '0;
        end
    end

    assign Rd_Data  = r_RdData;
    assign Rd_Valid = r_RdValid;
    assign Rd_Err   = r_RdErr;
    assign Busy     = Rst || (r_State == CLEAR);

endmodule

// File: tb/tb_sram_sdp_be.sv
// Bench for sram_sdp_be: three instances share stimulus (old-data, new-data and
// DEPTH=200); a scoreboard checks every read result of the old-data instance.
module tb_sram_sdp_be;

    logic        Clk;
    logic        Rst;
    logic        Wr_En;
    logic [7:0]  Wr_Addr;
    logic [31:0] Wr_Data;
    logic [3:0]  Wr_Be;
    logic        Rd_En;
    logic [7:0]  Rd_Addr;

    logic [31:0] rdData0, rdData1, rdData2;
    logic        rdValid0, rdValid1, rdValid2;
    logic        rdErr0, rdErr1, rdErr2;
    logic        busy0, busy1, busy2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sram_sdp_be #(.RDW_MODE(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Wr_Be(Wr_Be), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(rdData0),
        .Rd_Valid(rdValid0), .Rd_Err(rdErr0), .Busy(busy0));

    sram_sdp_be #(.RDW_MODE(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Wr_Be(Wr_Be), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(rdData1),
        .Rd_Valid(rdValid1), .Rd_Err(rdErr1), .Busy(busy1));

    sram_sdp_be #(.DEPTH(200)) dut2 (
        .Clk(Clk), .Rst(Rst), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Wr_Be(Wr_Be), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(rdData2),
        .Rd_Valid(rdValid2), .Rd_Err(rdErr2), .Busy(busy2));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          dueCyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        wrEn;
        logic [7:0]  wrAddr;
        logic [31:0] wrData;
        logic [3:0]  wrBe;
        logic        rdEn;
        logic [7:0]  rdAddr;
        logic        expValid;
        logic        expErr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [14];

    // Scoreboard monitor for dut0: each result must arrive exactly one cycle after its request.
    always @(negedge Clk) begin
        if (cyc > 0) begin
            if (sb.size() > 0 && sb[0].dueCyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_missing actual=no_result required=result_at_cycle_%0d", sb[0].dueCyc);
                void'(sb.pop_front());
            end
            if (rdValid0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected actual=Rd_Valid=1 data=%08h required=Rd_Valid=0", rdData0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.dueCyc != cyc || e.data !== rdData0 || e.err !== rdErr0) begin
                        errors++;
                        $display("[TB] FAIL sb_read actual=cyc%0d data=%08h err=%0b required=cyc%0d data=%08h err=%0b",
                                 cyc, rdData0, rdErr0, e.dueCyc, e.data, e.err);
                    end
                end
            end else begin
                checks++;
                if (rdData0 !== 32'h0 || rdErr0 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL idle_outputs actual=data=%08h err=%0b required=data=00000000 err=0",
                             rdData0, rdErr0);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%08h required=%08h", name, actual, required);
        end
    endtask

    task automatic driveIdle();
        Wr_En   = 1'b0;
        Wr_Addr = 8'h0;
        Wr_Data = 32'h0;
        Wr_Be   = 4'h0;
        Rd_En   = 1'b0;
        Rd_Addr = 8'h0;
    endtask

    // Drives one cycle of requests and registers the expected dut0 read result.
    task automatic applyStimulus(input vec_t v);
        Wr_En   = v.wrEn;
        Wr_Addr = v.wrAddr;
        Wr_Data = v.wrData;
        Wr_Be   = v.wrBe;
        Rd_En   = v.rdEn;
        Rd_Addr = v.rdAddr;
        if (v.expValid) begin
            exp_t e;
            e.data   = v.expData;
            e.err    = v.expErr;
            e.dueCyc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        driveIdle();
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Counts cycles from reset release until Busy drops on dut0 and dut2; 0 means timeout.
    task automatic measureBusy(input bit lockout, output int len0, output int len2);
        len0 = 0;
        len2 = 0;
        for (int k = 1; k <= 600; k++) begin
            if (lockout && k <= 3) begin
                Wr_En = 1'b1; Wr_Addr = 8'd3; Wr_Data = 32'hFFFF_FFFF; Wr_Be = 4'hF;
                Rd_En = 1'b1; Rd_Addr = 8'd3;
            end else begin
                driveIdle();
            end
            @(posedge Clk);
            #1;
            if (lockout && k <= 5) begin
                checkOutput("lockout_valid0", {31'h0, rdValid0}, 32'h0);
                checkOutput("lockout_valid1", {31'h0, rdValid1}, 32'h0);
            end
            if (!busy0 && len0 == 0) len0 = k;
            if (!busy2 && len2 == 0) len2 = k;
            if (len0 != 0 && len2 != 0) break;
        end
    endtask

    vec_t v;
    int   len0, len2;

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h7F, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h03, 1'b1, 1'b0, 32'h0000_0000};
        vecs[4]  = '{1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 8'h10, 32'h11223344, 4'h5, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h10, 1'b1, 1'b0, 32'hAA22_CC44};
        vecs[7]  = '{1'b1, 8'h20, 32'h12345678, 4'hF, 1'b1, 8'h10, 1'b1, 1'b0, 32'hAA22_CC44};
        vecs[8]  = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h20, 1'b1, 1'b0, 32'h1234_5678};
        vecs[9]  = '{1'b1, 8'h20, 32'hFFFFFFFF, 4'h0, 1'b1, 8'h20, 1'b1, 1'b0, 32'h1234_5678};
        vecs[10] = '{1'b1, 8'hFF, 32'hCAFEF00D, 4'h8, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'hCA00_0000};
        vecs[12] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h7F, 1'b1, 1'b0, 32'h0000_0000};
        vecs[13] = '{1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 8'h20, 1'b1, 1'b0, 32'h1234_5678};

        Rst = 1'b1;
        driveIdle();
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        checkOutput("reset_busy",  {31'h0, busy0},    32'h1);
        checkOutput("reset_valid", {31'h0, rdValid0}, 32'h0);
        checkOutput("reset_err",   {31'h0, rdErr0},   32'h0);
        checkOutput("reset_data",  rdData0,           32'h0);

        // First clear, with requests to address 3 attempted while busy.
        Rst = 1'b0;
        measureBusy(1'b1, len0, len2);
        checkOutput("clear_len_256", len0, 32'd256);
        checkOutput("clear_len_200", len2, 32'd200);
        idleCycles(2);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end
        idleCycles(2);

        // Same-address read during write: old data vs merged new data.
        v = '{1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b1, 8'h05, 1'b1, 1'b0, 32'h0000_0000};
        applyStimulus(v);
        checkOutput("rdw1_valid", {31'h0, rdValid1}, 32'h1);
        checkOutput("rdw1_data",  rdData1, 32'hDEAD_BEEF);
        v = '{1'b1, 8'h06, 32'h11223344, 4'h3, 1'b1, 8'h06, 1'b1, 1'b0, 32'h0000_0000};
        applyStimulus(v);
        checkOutput("rdw1_partial", rdData1, 32'h0000_3344);
        v = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h05, 1'b1, 1'b0, 32'hDEAD_BEEF};
        applyStimulus(v);
        checkOutput("rdw1_after", rdData1, 32'hDEAD_BEEF);
        idleCycles(2);

        // Out-of-range handling on the DEPTH=200 instance.
        v = '{1'b1, 8'd250, 32'h55555555, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
        applyStimulus(v);
        v = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'd250, 1'b1, 1'b0, 32'h5555_5555};
        applyStimulus(v);
        checkOutput("oor_valid", {31'h0, rdValid2}, 32'h1);
        checkOutput("oor_err",   {31'h0, rdErr2},   32'h1);
        checkOutput("oor_data",  rdData2,           32'h0);
        v = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'd50, 1'b1, 1'b0, 32'h0};
        applyStimulus(v);
        checkOutput("oor_nowrap_data", rdData2, 32'h0);
        v = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'd199, 1'b1, 1'b0, 32'h0};
        applyStimulus(v);
        checkOutput("oor_last_err",   {31'h0, rdErr2},   32'h0);
        checkOutput("oor_last_valid", {31'h0, rdValid2}, 32'h1);
        idleCycles(2);

        // Reset asserted when the clear pointer has reached 100 restarts the sweep.
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge Clk); #1;
        end
        checkOutput("midclear_busy", {31'h0, busy0}, 32'h1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        checkOutput("midclear_rst_busy", {31'h0, busy0}, 32'h1);
        Rst = 1'b0;
        measureBusy(1'b0, len0, len2);
        checkOutput("midclear_len_256", len0, 32'd256);
        checkOutput("midclear_len_200", len2, 32'd200);
        idleCycles(1);

        v = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10, 1'b1, 1'b0, 32'h0};
        applyStimulus(v);
        v = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h05, 1'b1, 1'b0, 32'h0};
        applyStimulus(v);
        idleCycles(3);
        checkOutput("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
